// File: rtl/kitten_step_sequencer.sv
// kitten_step_sequencer
// Per-step phase controller for a Kitten SNN tile: runs the enabled presynaptic
// projections in index order, waits for the current accumulator to drain, runs
// the LIF population sweep, and repeats for the programmed number of steps.
// It also owns the I_post BRAM port mux and adds a per-phase watchdog, abort,
// a step counter and error reporting. All control outputs are Moore outputs
// decoded from the registered state.

module kitten_step_sequencer #(
    parameter int                N_PROJ     = 4,
    parameter int                STEP_W     = 16,
    parameter int                TMO_W      = 20,
    parameter logic [TMO_W-1:0]  TIMEOUT    = TMO_W'(20'hFFFFF),
    parameter int                ADDRW_POST = 12,
    localparam int               SEL_W      = (N_PROJ > 1) ? $clog2(N_PROJ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,

    // host control
    input  logic                  i_run,
    input  logic                  i_abort,
    input  logic [STEP_W-1:0]     i_num_steps,
    input  logic [N_PROJ-1:0]     i_proj_mask,

    // projection handshake
    output logic                  o_proj_start,
    output logic [SEL_W-1:0]      o_proj_sel,
    input  logic                  i_proj_done,
    input  logic                  i_acc_idle,

    // population handshake
    output logic                  o_pop_start,
    input  logic                  i_pop_done,

    // status
    output logic                  o_step_done,
    output logic [STEP_W-1:0]     o_step_count,
    output logic                  o_run_done,
    output logic                  o_busy,
    output logic                  o_err_timeout,
    output logic [1:0]            o_err_phase,
    output logic                  o_aborted,

    // accumulator I_post port
    input  logic [ADDRW_POST-1:0] i_acc_addr,
    input  logic                  i_acc_we,
    input  logic [31:0]           i_acc_din,

    // LIF population I_post port
    input  logic [ADDRW_POST-1:0] i_lif_addr,
    input  logic                  i_lif_we,
    input  logic [31:0]           i_lif_din,

    // to I_post BRAM
    output logic [ADDRW_POST-1:0] o_I_addr,
    output logic                  o_I_we,
    output logic [31:0]           o_I_din
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PROJ     = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_POP      = 3'd3;
    localparam logic [2:0] S_STEP_END = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_ERR      = 3'd6;

    // Phase codes reported on o_err_phase
    localparam logic [1:0] PH_PROJ  = 2'd1;
    localparam logic [1:0] PH_DRAIN = 2'd2;
    localparam logic [1:0] PH_POP   = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [STEP_W-1:0] num_steps_q;
    logic [N_PROJ-1:0] mask_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic [TMO_W-1:0]  wdog_q;
    logic [1:0]        err_phase_q;
    logic              aborted_q;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Lowest set bit of mask at index >= from. Result is {found, index}.
    function automatic logic [SEL_W:0] find_set(input logic [N_PROJ-1:0] mask,
                                                input logic [SEL_W:0]    from);
        logic [SEL_W:0] res;
        res = '0;
        // Scan downwards so the lowest qualifying index is the last one written.
        for (int i = N_PROJ - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res = {1'b1, SEL_W'(i)};
            end
        end
        return res;
    endfunction

    logic [SEL_W:0]    first_in;     // first enabled projection of the incoming mask
    logic [SEL_W:0]    first_q;      // first enabled projection of the latched mask
    logic [SEL_W:0]    next_q;       // next enabled projection above the current one
    logic [STEP_W-1:0] cnt_inc;      // wraps modulo 2^STEP_W
    logic [TMO_W-1:0]  wdog_inc;
    logic              in_phase;     // watchdog-supervised states
    logic              timed_out;
    logic              run_start;
    logic              abort_hit;
    logic [1:0]        phase_code;

    // Derived control terms shared by the next-state logic and the datapath.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        first_in   = find_set(i_proj_mask, '0);
        first_q    = find_set(mask_q, '0);
        next_q     = find_set(mask_q, {1'b0, sel_q} + (SEL_W + 1)'(1));
        cnt_inc    = step_cnt_q + STEP_W'(1);
        wdog_inc   = wdog_q + TMO_W'(1);
        in_phase   = (state_q == S_PROJ) || (state_q == S_DRAIN) || (state_q == S_POP);
        timed_out  = in_phase && (TIMEOUT != '0) && (wdog_inc == TIMEOUT);
        run_start  = (state_q == S_IDLE) && i_run;
        abort_hit  = i_abort && (in_phase || (state_q == S_STEP_END));
        case (state_q)
            S_PROJ:  phase_code = PH_PROJ;
            S_DRAIN: phase_code = PH_DRAIN;
            S_POP:   phase_code = PH_POP;
            default: phase_code = 2'd0;
        endcase
    end

    // Next-state and projection-select logic; abort outranks done and timeout.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    if (i_num_steps == '0) begin
                        state_d = S_DONE;
                    end else if (!first_in[SEL_W]) begin
                        state_d = S_POP;
                    end else begin
                        state_d = S_PROJ;
                        sel_d   = first_in[SEL_W-1:0];
                    end
                end
            end
            S_PROJ: begin
                if (abort_hit)        state_d = S_IDLE;
                else if (i_proj_done) state_d = S_DRAIN;
                else if (timed_out)   state_d = S_ERR;
            end
            S_DRAIN: begin
                if (abort_hit) begin
                    state_d = S_IDLE;
                end else if (i_acc_idle) begin
                    if (next_q[SEL_W]) begin
                        state_d = S_PROJ;
                        sel_d   = next_q[SEL_W-1:0];
                    end else begin
                        state_d = S_POP;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_POP: begin
                if (abort_hit)       state_d = S_IDLE;
                else if (i_pop_done) state_d = S_STEP_END;
                else if (timed_out)  state_d = S_ERR;
            end
            S_STEP_END: begin
                if (abort_hit) begin
                    state_d = S_IDLE;
                end else if (cnt_inc == num_steps_q) begin
                    state_d = S_DONE;
                end else if (first_q[SEL_W]) begin
                    state_d = S_PROJ;
                    sel_d   = first_q[SEL_W-1:0];
                end else begin
                    state_d = S_POP;
                end
            end
            S_DONE, S_ERR: begin
                if (!i_run) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, run configuration, counters and sticky status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            num_steps_q <= '0;
            mask_q      <= '0;
            step_cnt_q  <= '0;
            wdog_q      <= '0;
            err_phase_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            state_q <= state_d;
            sel_q   <= sel_d;

            if (run_start) begin
                num_steps_q <= i_num_steps;
                mask_q      <= i_proj_mask;
                step_cnt_q  <= '0;
                err_phase_q <= '0;
                aborted_q   <= 1'b0;
            end

            // The step_done pulse has already been shown in STEP_END, so the
            // step is counted even if an abort arrives in that same cycle.
            if (state_q == S_STEP_END) begin
                step_cnt_q <= cnt_inc;
            end

            if (abort_hit) begin
                aborted_q <= 1'b1;
            end

            if ((state_d == S_ERR) && (state_q != S_ERR)) begin
                err_phase_q <= phase_code;
            end

            // Watchdog restarts on every state change and only runs in phases.
            if (state_d != state_q) begin
                wdog_q <= '0;
            end else if (in_phase) begin
                wdog_q <= wdog_inc;
            end
        end
    end

    // Moore status outputs decoded from the registered state.
    always_comb begin
        o_proj_start  = (state_q == S_PROJ);
        o_pop_start   = (state_q == S_POP);
        o_step_done   = (state_q == S_STEP_END);
        o_run_done    = (state_q == S_DONE);
        o_err_timeout = (state_q == S_ERR);
        o_busy        = (state_q == S_PROJ) || (state_q == S_DRAIN) ||
                        (state_q == S_POP)  || (state_q == S_STEP_END);
        o_proj_sel    = sel_q;
        o_step_count  = step_cnt_q;
        o_err_phase   = err_phase_q;
        o_aborted     = aborted_q;
    end

    // I_post port mux: LIF owns the BRAM during POP, the accumulator otherwise;
    // writes are blocked whenever no run phase is active.
    always_comb begin
        o_I_addr = i_acc_addr;
        o_I_din  = i_acc_din;
        o_I_we   = 1'b0;
        case (state_q)
            S_POP: begin
                o_I_addr = i_lif_addr;
                o_I_din  = i_lif_din;
                o_I_we   = i_lif_we;
            end
            S_PROJ, S_DRAIN, S_STEP_END: begin
                o_I_we = i_acc_we;
            end
            default: o_I_we = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_kitten_step_sequencer.sv
// Self-checking bench for kitten_step_sequencer: a table of whole-run
// scenarios driven by a fixed-latency responder, plus hand-written sequences
// for drain stall, port mux, watchdog, abort and asynchronous reset.

module tb_kitten_step_sequencer;

    localparam int               N_PROJ     = 4;
    localparam int               STEP_W     = 16;
    localparam int               TMO_W      = 20;
    localparam logic [TMO_W-1:0] TIMEOUT    = 20'd100;
    localparam int               ADDRW_POST = 12;
    localparam int               SEL_W      = 2;
    localparam int               LAT        = 3;

    logic                  clk;
    logic                  rst;
    logic                  i_run;
    logic                  i_abort;
    logic [STEP_W-1:0]     i_num_steps;
    logic [N_PROJ-1:0]     i_proj_mask;
    logic                  o_proj_start;
    logic [SEL_W-1:0]      o_proj_sel;
    logic                  i_proj_done;
    logic                  i_acc_idle;
    logic                  o_pop_start;
    logic                  i_pop_done;
    logic                  o_step_done;
    logic [STEP_W-1:0]     o_step_count;
    logic                  o_run_done;
    logic                  o_busy;
    logic                  o_err_timeout;
    logic [1:0]            o_err_phase;
    logic                  o_aborted;
    logic [ADDRW_POST-1:0] i_acc_addr;
    logic                  i_acc_we;
    logic [31:0]           i_acc_din;
    logic [ADDRW_POST-1:0] i_lif_addr;
    logic                  i_lif_we;
    logic [31:0]           i_lif_din;
    logic [ADDRW_POST-1:0] o_I_addr;
    logic                  o_I_we;
    logic [31:0]           o_I_din;

    kitten_step_sequencer #(
        .N_PROJ     (N_PROJ),
        .STEP_W     (STEP_W),
        .TMO_W      (TMO_W),
        .TIMEOUT    (TIMEOUT),
        .ADDRW_POST (ADDRW_POST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_run         (i_run),
        .i_abort       (i_abort),
        .i_num_steps   (i_num_steps),
        .i_proj_mask   (i_proj_mask),
        .o_proj_start  (o_proj_start),
        .o_proj_sel    (o_proj_sel),
        .i_proj_done   (i_proj_done),
        .i_acc_idle    (i_acc_idle),
        .o_pop_start   (o_pop_start),
        .i_pop_done    (i_pop_done),
        .o_step_done   (o_step_done),
        .o_step_count  (o_step_count),
        .o_run_done    (o_run_done),
        .o_busy        (o_busy),
        .o_err_timeout (o_err_timeout),
        .o_err_phase   (o_err_phase),
        .o_aborted     (o_aborted),
        .i_acc_addr    (i_acc_addr),
        .i_acc_we      (i_acc_we),
        .i_acc_din     (i_acc_din),
        .i_lif_addr    (i_lif_addr),
        .i_lif_we      (i_lif_we),
        .i_lif_din     (i_lif_din),
        .o_I_addr      (o_I_addr),
        .o_I_we        (o_I_we),
        .o_I_din       (o_I_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Whole-run scenarios. exp_seq holds the expected o_proj_sel of each PROJ
    // phase in order, two bits per entry, entry k at bits [2k+1:2k].
    typedef struct {
        logic [STEP_W-1:0] num_steps;
        logic [N_PROJ-1:0] mask;
        int                exp_nproj;
        logic [15:0]       exp_seq;
        int                exp_pops;
    } scen_t;

    scen_t scen [6];

    task automatic run_scenario(input int idx);
        int          nproj, npops, nstep;
        int          proj_age, pop_age, drain_age;
        logic [15:0] seq;
        logic        prev_proj, prev_pop, prev_drain, in_drain;
        bit          finished;
        nproj = 0; npops = 0; nstep = 0;
        proj_age = 0; pop_age = 0; drain_age = 0;
        seq = '0;
        prev_proj = 1'b0; prev_pop = 1'b0; prev_drain = 1'b0;
        finished = 1'b0;
        i_num_steps = scen[idx].num_steps;
        i_proj_mask = scen[idx].mask;
        i_run       = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            tick();
            in_drain = o_busy && !o_proj_start && !o_pop_start && !o_step_done;
            if (o_proj_start && !prev_proj) begin
                if (nproj < 8) seq[2*nproj +: 2] = o_proj_sel;
                nproj++;
            end
            if (o_pop_start && !prev_pop) npops++;
            if (o_step_done) nstep++;
            proj_age  = o_proj_start ? (prev_proj  ? proj_age  + 1 : 1) : 0;
            pop_age   = o_pop_start  ? (prev_pop   ? pop_age   + 1 : 1) : 0;
            drain_age = in_drain     ? (prev_drain ? drain_age + 1 : 1) : 0;
            i_proj_done = o_proj_start && (proj_age == LAT);
            i_acc_idle  = in_drain && (drain_age == LAT);
            i_pop_done  = o_pop_start && (pop_age == LAT);
            prev_proj  = o_proj_start;
            prev_pop   = o_pop_start;
            prev_drain = in_drain;
            if (o_run_done || o_err_timeout) finished = 1'b1;
        end
        i_proj_done = 1'b0;
        i_acc_idle  = 1'b0;
        i_pop_done  = 1'b0;
        check($sformatf("scen%0d finished", idx), 64'(finished), 64'd1);
        check($sformatf("scen%0d nproj", idx), 64'(nproj), 64'(scen[idx].exp_nproj));
        check($sformatf("scen%0d sel_seq", idx), 64'(seq), 64'(scen[idx].exp_seq));
        check($sformatf("scen%0d npops", idx), 64'(npops), 64'(scen[idx].exp_pops));
        check($sformatf("scen%0d step_pulses", idx), 64'(nstep), 64'(scen[idx].num_steps));
        check($sformatf("scen%0d step_count", idx), 64'(o_step_count), 64'(scen[idx].num_steps));
        check($sformatf("scen%0d run_done", idx), 64'(o_run_done), 64'd1);
        check($sformatf("scen%0d err", idx), 64'(o_err_timeout), 64'd0);
        i_run = 1'b0;
        tick();
        check($sformatf("scen%0d idle_busy", idx), 64'(o_busy), 64'd0);
        check($sformatf("scen%0d idle_done", idx), 64'(o_run_done), 64'd0);
    endtask

    initial begin
        scen[0] = '{num_steps: 16'd2, mask: 4'b0101, exp_nproj: 4, exp_seq: 16'h0088, exp_pops: 2};
        scen[1] = '{num_steps: 16'd3, mask: 4'b0000, exp_nproj: 0, exp_seq: 16'h0000, exp_pops: 3};
        scen[2] = '{num_steps: 16'd1, mask: 4'b1000, exp_nproj: 1, exp_seq: 16'h0003, exp_pops: 1};
        scen[3] = '{num_steps: 16'd1, mask: 4'b1111, exp_nproj: 4, exp_seq: 16'h00E4, exp_pops: 1};
        scen[4] = '{num_steps: 16'd2, mask: 4'b0110, exp_nproj: 4, exp_seq: 16'h0099, exp_pops: 2};
        scen[5] = '{num_steps: 16'd0, mask: 4'b1111, exp_nproj: 0, exp_seq: 16'h0000, exp_pops: 0};

        rst = 1'b1;
        i_run = 1'b0; i_abort = 1'b0; i_num_steps = '0; i_proj_mask = '0;
        i_proj_done = 1'b0; i_acc_idle = 1'b0; i_pop_done = 1'b0;
        i_acc_addr = '0; i_acc_we = 1'b0; i_acc_din = '0;
        i_lif_addr = '0; i_lif_we = 1'b0; i_lif_din = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst busy",       64'(o_busy),        64'd0);
        check("rst proj_start", 64'(o_proj_start),  64'd0);
        check("rst proj_sel",   64'(o_proj_sel),    64'd0);
        check("rst pop_start",  64'(o_pop_start),   64'd0);
        check("rst step_done",  64'(o_step_done),   64'd0);
        check("rst step_count", 64'(o_step_count),  64'd0);
        check("rst run_done",   64'(o_run_done),    64'd0);
        check("rst err",        64'(o_err_timeout), 64'd0);
        check("rst err_phase",  64'(o_err_phase),   64'd0);
        check("rst aborted",    64'(o_aborted),     64'd0);
        check("rst I_we",       64'(o_I_we),        64'd0);

        for (int s = 0; s < 6; s++) run_scenario(s);

        // num_steps==0: run_done exactly one cycle after i_run, no phases
        i_num_steps = 16'd0; i_proj_mask = 4'b0011; i_run = 1'b1;
        tick();
        check("zero run_done", 64'(o_run_done), 64'd1);
        check("zero phases", 64'({o_busy, o_proj_start, o_pop_start}), 64'd0);
        i_run = 1'b0;
        tick();

        // Drain stall and accumulator/LIF port routing
        i_num_steps = 16'd1; i_proj_mask = 4'b0001; i_run = 1'b1;
        tick();
        check("C proj_start", 64'(o_proj_start), 64'd1);
        check("C busy",       64'(o_busy),       64'd1);
        check("C sel",        64'(o_proj_sel),   64'd0);
        i_lif_we = 1'b1; i_acc_we = 1'b0; #1;
        check("C proj lif_we blocked", 64'(o_I_we), 64'd0);
        i_acc_we = 1'b1; i_acc_addr = 12'h123; #1;
        check("C proj acc_we", 64'(o_I_we),   64'd1);
        check("C proj addr",   64'(o_I_addr), 64'h123);
        i_proj_done = 1'b1;
        tick();
        i_proj_done = 1'b0;
        check("C drain entry", 64'({o_busy, o_proj_start}), 64'b10);
        for (int i = 0; i < 50; i++) begin
            logic exp_we;
            exp_we = (i % 2) == 1;
            i_acc_we = exp_we;
            i_acc_addr = ADDRW_POST'(i);
            i_proj_done = (i == 10);
            #1;
            check($sformatf("C drain%0d we", i), 64'(o_I_we), 64'(exp_we));
            check($sformatf("C drain%0d stall", i), 64'({o_proj_start, o_pop_start}), 64'd0);
            tick();
        end
        i_proj_done = 1'b0;
        i_acc_idle = 1'b1;
        tick();
        i_acc_idle = 1'b0;
        check("C pop after drain", 64'(o_pop_start), 64'd1);
        i_lif_we = 1'b1; i_acc_we = 1'b0; i_lif_addr = 12'hABC; i_lif_din = 32'hCAFEF00D; #1;
        check("C pop lif_we",   64'(o_I_we),   64'd1);
        check("C pop lif_addr", 64'(o_I_addr), 64'hABC);
        check("C pop lif_din",  64'(o_I_din),  64'hCAFEF00D);
        i_lif_we = 1'b0; i_acc_we = 1'b1; #1;
        check("C pop acc_we blocked", 64'(o_I_we), 64'd0);
        i_pop_done = 1'b1;
        tick();
        i_pop_done = 1'b0;
        check("C step_done",       64'(o_step_done),  64'd1);
        check("C step_count pre",  64'(o_step_count), 64'd0);
        tick();
        check("C run_done",        64'(o_run_done),   64'd1);
        check("C step_count post", 64'(o_step_count), 64'd1);
        check("C done busy",       64'(o_busy),       64'd0);
        i_acc_we = 1'b1; i_acc_addr = 12'h055; #1;
        check("C done we blocked", 64'(o_I_we),   64'd0);
        check("C done addr",       64'(o_I_addr), 64'h055);
        i_run = 1'b0; i_acc_we = 1'b0;
        tick();
        check("C back idle", 64'(o_run_done), 64'd0);

        // Watchdog in POP: 100th POP cycle still POP, ERR on the next
        i_num_steps = 16'd1; i_proj_mask = 4'b0000; i_run = 1'b1;
        tick();
        repeat (99) tick();
        check("D pop cycle100", 64'({o_pop_start, o_err_timeout}), 64'b10);
        tick();
        check("D err",       64'(o_err_timeout), 64'd1);
        check("D err_phase", 64'(o_err_phase),   64'd3);
        check("D err phases", 64'({o_busy, o_pop_start}), 64'd0);
        i_acc_we = 1'b1; i_lif_we = 1'b1; #1;
        check("D err we blocked", 64'(o_I_we), 64'd0);
        i_acc_we = 1'b0; i_lif_we = 1'b0; i_run = 1'b0;
        tick();
        check("D idle err",   64'(o_err_timeout), 64'd0);
        check("D idle phase", 64'(o_err_phase),   64'd3);

        // Watchdog in PROJ: sel holds through ERR
        i_num_steps = 16'd1; i_proj_mask = 4'b0100; i_run = 1'b1;
        tick();
        check("D2 sel", 64'(o_proj_sel), 64'd2);
        repeat (99) tick();
        check("D2 proj cycle100", 64'(o_proj_start), 64'd1);
        tick();
        check("D2 err",       64'(o_err_timeout), 64'd1);
        check("D2 err_phase", 64'(o_err_phase),   64'd1);
        check("D2 sel held",  64'(o_proj_sel),    64'd2);
        i_run = 1'b0;
        tick();

        // Abort in POP of step 1, with pop_done in the same cycle
        i_num_steps = 16'd3; i_proj_mask = 4'b0000; i_run = 1'b1;
        tick();
        check("E pop0", 64'(o_pop_start), 64'd1);
        check("E err_phase cleared", 64'(o_err_phase), 64'd0);
        i_pop_done = 1'b1;
        tick();
        i_pop_done = 1'b0;
        check("E step_done0", 64'(o_step_done), 64'd1);
        tick();
        check("E pop1",       64'(o_pop_start),  64'd1);
        check("E count1",     64'(o_step_count), 64'd1);
        i_abort = 1'b1; i_pop_done = 1'b1; i_run = 1'b0;
        tick();
        i_abort = 1'b0; i_pop_done = 1'b0;
        check("E aborted",       64'(o_aborted),    64'd1);
        check("E abort idle",    64'({o_busy, o_pop_start, o_step_done}), 64'd0);
        check("E abort count",   64'(o_step_count), 64'd1);
        i_num_steps = 16'd1; i_run = 1'b1;
        tick();
        check("E aborted cleared", 64'(o_aborted),   64'd0);
        check("E rerun pop",       64'(o_pop_start), 64'd1);
        check("E rerun count",     64'(o_step_count), 64'd0);
        i_pop_done = 1'b1;
        tick();
        i_pop_done = 1'b0;
        tick();
        check("E rerun done", 64'(o_run_done), 64'd1);
        i_run = 1'b0;
        tick();

        // Asynchronous reset mid-run drops the write enable at once
        i_num_steps = 16'd2; i_proj_mask = 4'b0001; i_run = 1'b1;
        tick();
        i_acc_we = 1'b1; #1;
        check("R we before", 64'(o_I_we), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("R we async", 64'(o_I_we), 64'd0);
        check("R busy async", 64'(o_busy), 64'd0);
        i_run = 1'b0; i_acc_we = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
